// File: rtl/can_frame_decoder.sv
// CAN 2.0A receive frame decoder: parses the destuffed bit stream, checks CRC-15 and
// the fixed-form fields, and publishes ID/RTR/DLC/data with a one-cycle frame_valid.
module can_frame_decoder #(
    parameter int IDLE_BITS = 11,
    parameter int EOF_BITS  = 7,
    parameter int IFS_BITS  = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        bit_valid,
    input  logic        bit_in,
    output logic        busy,
    output logic        frame_valid,
    output logic [10:0] id,
    output logic        rtr,
    output logic [3:0]  dlc,
    output logic [63:0] data,
    output logic        ack_seen,
    output logic        crc_err,
    output logic        form_err,
    output logic        ext_err
);

    typedef enum logic [3:0] {
        S_WAIT_IDLE, S_IDLE, S_ARB, S_CTRL, S_DATA, S_CRC,
        S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF, S_INTERMISSION
    } state_t;

    localparam logic [6:0] IDLE_LAST = 7'(IDLE_BITS - 1);
    localparam logic [6:0] EOF_LAST  = 7'(EOF_BITS - 1);
    localparam logic [6:0] IFS_LAST  = 7'(IFS_BITS - 1);

    state_t      state, state_nxt;
    logic [6:0]  cnt, cnt_nxt;
    logic [14:0] crc, crc_rx;
    logic [10:0] id_sh;
    logic        rtr_sh, ack_sh;
    logic [3:0]  dlc_sh, dlc_new, nbytes, nbytes_calc;
    logic [63:0] data_sh;
    logic [6:0]  data_last;
    logic        fv_nxt, crc_err_nxt, form_err_nxt, ext_err_nxt;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        crc_step = {c[13:0], 1'b0} ^ ((b ^ c[14]) ? 15'h4599 : 15'h0000);
    endfunction

    // The last DLC bit is still on bit_in when the byte count is decided.
    assign dlc_new     = {dlc_sh[2:0], bit_in};
    assign nbytes_calc = rtr_sh ? 4'd0 : ((dlc_new > 4'd8) ? 4'd8 : dlc_new);
    assign data_last   = {nbytes, 3'b000} - 7'd1;

    assign busy = (state inside {S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL,
                                 S_ACK_SLOT, S_ACK_DEL, S_EOF});

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_WAIT_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        fv_nxt       = 1'b0;
        crc_err_nxt  = 1'b0;
        form_err_nxt = 1'b0;
        ext_err_nxt  = 1'b0;
        if (bit_valid) begin
            case (state)
                S_WAIT_IDLE: begin
                    if (!bit_in) begin
                        cnt_nxt = '0;
                    end else if (cnt == IDLE_LAST) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
                S_IDLE: begin
                    if (!bit_in) begin
                        state_nxt = S_ARB;
                        cnt_nxt   = '0;
                    end
                end
                S_ARB: begin
                    // 11 ID bits followed by RTR
                    if (cnt == 7'd11) begin
                        state_nxt = S_CTRL;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
                S_CTRL: begin
                    // IDE, r0, then DLC[3:0]
                    if (cnt == 7'd0 && bit_in) begin
                        ext_err_nxt = 1'b1;
                        state_nxt   = S_WAIT_IDLE;
                        cnt_nxt     = '0;
                    end else if (cnt == 7'd5) begin
                        state_nxt = (nbytes_calc == 4'd0) ? S_CRC : S_DATA;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
                S_DATA: begin
                    if (cnt == data_last) begin
                        state_nxt = S_CRC;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
                S_CRC: begin
                    if (cnt == 7'd14) begin
                        state_nxt = S_CRC_DEL;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
                S_CRC_DEL: begin
                    if (crc_rx != crc) begin
                        crc_err_nxt = 1'b1;
                        state_nxt   = S_WAIT_IDLE;
                    end else if (!bit_in) begin
                        form_err_nxt = 1'b1;
                        state_nxt    = S_WAIT_IDLE;
                    end else begin
                        state_nxt = S_ACK_SLOT;
                    end
                    cnt_nxt = '0;
                end
                S_ACK_SLOT: state_nxt = S_ACK_DEL;
                S_ACK_DEL: begin
                    if (!bit_in) begin
                        form_err_nxt = 1'b1;
                        state_nxt    = S_WAIT_IDLE;
                    end else begin
                        state_nxt = S_EOF;
                    end
                    cnt_nxt = '0;
                end
                S_EOF: begin
                    if (!bit_in) begin
                        form_err_nxt = 1'b1;
                        state_nxt    = S_WAIT_IDLE;
                        cnt_nxt      = '0;
                    end else if (cnt == EOF_LAST) begin
                        fv_nxt    = 1'b1;
                        state_nxt = S_INTERMISSION;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
                S_INTERMISSION: begin
                    if (!bit_in) begin
                        form_err_nxt = 1'b1;
                        state_nxt    = S_WAIT_IDLE;
                        cnt_nxt      = '0;
                    end else if (cnt == IFS_LAST) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
                default: begin
                    state_nxt = S_WAIT_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            crc         <= '0;
            crc_rx      <= '0;
            id_sh       <= '0;
            rtr_sh      <= 1'b0;
            dlc_sh      <= '0;
            nbytes      <= '0;
            data_sh     <= '0;
            ack_sh      <= 1'b0;
            frame_valid <= 1'b0;
            crc_err     <= 1'b0;
            form_err    <= 1'b0;
            ext_err     <= 1'b0;
            id          <= '0;
            rtr         <= 1'b0;
            dlc         <= '0;
            data        <= '0;
            ack_seen    <= 1'b0;
        end else begin
            frame_valid <= fv_nxt;
            crc_err     <= crc_err_nxt;
            form_err    <= form_err_nxt;
            ext_err     <= ext_err_nxt;
            if (bit_valid) begin
                case (state)
                    S_IDLE: begin
                        if (!bit_in) begin
                            crc     <= crc_step(15'h0000, bit_in);
                            data_sh <= '0;
                        end
                    end
                    S_ARB: begin
                        crc <= crc_step(crc, bit_in);
                        if (cnt < 7'd11) id_sh  <= {id_sh[9:0], bit_in};
                        else             rtr_sh <= bit_in;
                    end
                    S_CTRL: begin
                        crc <= crc_step(crc, bit_in);
                        if (cnt >= 7'd2) dlc_sh <= dlc_new;
                        if (cnt == 7'd5) nbytes <= nbytes_calc;
                    end
                    S_DATA: begin
                        // first data bit lands in bit 63
                        crc                <= crc_step(crc, bit_in);
                        data_sh[~cnt[5:0]] <= bit_in;
                    end
                    S_CRC:      crc_rx <= {crc_rx[13:0], bit_in};
                    S_ACK_SLOT: ack_sh <= ~bit_in;
                    default: ;
                endcase
            end
            if (fv_nxt) begin
                id       <= id_sh;
                rtr      <= rtr_sh;
                dlc      <= dlc_sh;
                data     <= data_sh;
                ack_seen <= ack_sh;
            end
        end
    end

endmodule

// File: tb/tb_can_frame_decoder.sv
// Directed bench for can_frame_decoder: stimulus pushes expected responses into a
// queue, a negedge monitor pops and compares whenever a pulse output fires.
module tb_can_frame_decoder;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b1;
    logic        busy, frame_valid, rtr, ack_seen, crc_err, form_err, ext_err;
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;

    can_frame_decoder dut (
        .CLK(CLK), .RST_N(RST_N), .bit_valid(bit_valid), .bit_in(bit_in),
        .busy(busy), .frame_valid(frame_valid), .id(id), .rtr(rtr), .dlc(dlc),
        .data(data), .ack_seen(ack_seen), .crc_err(crc_err), .form_err(form_err),
        .ext_err(ext_err)
    );

    always #5 CLK = ~CLK;

    typedef enum int {K_FRAME, K_CRC, K_FORM, K_EXT} kind_e;
    typedef struct {
        kind_e       kind;
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic        ack;
    } exp_t;

    exp_t exp_q[$];
    logic bits_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   hdr_len;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [14:0] crc_model(input logic [14:0] c, input logic b);
        crc_model = {c[13:0], 1'b0} ^ ((b ^ c[14]) ? 15'h4599 : 15'h0000);
    endfunction

    // Build a destuffed frame in bits_q; hdr_len = SOF..last data bit.
    task automatic build(input logic [10:0] fid, input logic frtr, input logic fide,
                         input logic [3:0] fdlc, input logic [63:0] fdata,
                         input logic ack_dom, input logic [14:0] crc_flip);
        logic [14:0] c;
        int nb;
        bits_q.delete();
        bits_q.push_back(1'b0);
        for (int i = 10; i >= 0; i--) bits_q.push_back(fid[i]);
        bits_q.push_back(frtr);
        bits_q.push_back(fide);
        bits_q.push_back(1'b0);
        for (int i = 3; i >= 0; i--) bits_q.push_back(fdlc[i]);
        nb = frtr ? 0 : ((fdlc > 4'd8) ? 8 : int'(fdlc));
        for (int i = 0; i < nb * 8; i++) bits_q.push_back(fdata[63-i]);
        hdr_len = bits_q.size();
        c = '0;
        for (int i = 0; i < hdr_len; i++) c = crc_model(c, bits_q[i]);
        c = c ^ crc_flip;
        for (int i = 14; i >= 0; i--) bits_q.push_back(c[i]);
        bits_q.push_back(1'b1);
        bits_q.push_back(!ack_dom);
        bits_q.push_back(1'b1);
        for (int i = 0; i < 7; i++) bits_q.push_back(1'b1);
    endtask

    task automatic push_exp(input kind_e k, input logic [10:0] fid, input logic frtr,
                            input logic [3:0] fdlc, input logic [63:0] fdata, input logic fack);
        exp_t e;
        e.kind = k; e.id = fid; e.rtr = frtr; e.dlc = fdlc; e.data = fdata; e.ack = fack;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        @(negedge CLK);
        bit_valid = 1'b0;
        bit_in    = 1'b1;
    endtask

    task automatic send_rec(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_range(input int lo, input int hi, input int maxgap);
        for (int i = lo; i < hi; i++) begin
            send_bit(bits_q[i]);
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge CLK);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_id"}, 64'(id), 64'h0);
        chk({tag, "_data"}, data, 64'h0);
        chk({tag, "_misc"}, 64'({busy, frame_valid, crc_err, form_err, ext_err, rtr, ack_seen, dlc}), 64'h0);
    endtask

    // Monitor
    exp_t  mon_e;
    kind_e mon_k;
    int    mon_np;
    always @(negedge CLK) begin
        mon_np = int'(frame_valid) + int'(crc_err) + int'(form_err) + int'(ext_err);
        if (mon_np > 0) begin
            chk("pulse_exclusive", 64'(mon_np), 64'd1);
            mon_k = frame_valid ? K_FRAME : crc_err ? K_CRC : form_err ? K_FORM : K_EXT;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: got kind %0d expected none", int'(mon_k));
            end else begin
                mon_e = exp_q.pop_front();
                chk("kind", 64'(mon_k), 64'(mon_e.kind));
                if (mon_e.kind == K_FRAME) begin
                    chk("id", 64'(id), 64'(mon_e.id));
                    chk("rtr", 64'(rtr), 64'(mon_e.rtr));
                    chk("dlc", 64'(dlc), 64'(mon_e.dlc));
                    chk("data", data, mon_e.data);
                    chk("ack_seen", 64'(ack_seen), 64'(mon_e.ack));
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk_zero("reset");
        RST_N = 1'b1;
        @(negedge CLK);

        // fewer than IDLE_BITS recessive, then dominant: no SOF
        send_rec(5);
        send_bit(1'b0);
        send_bit(1'b0);
        chk("no_sof_busy", 64'(busy), 64'd0);
        send_rec(11);

        // frame A
        push_exp(K_FRAME, 11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 1'b1);
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 1'b1, 15'h0);
        send_range(0, 5, 0);
        chk("busy_in_frame", 64'(busy), 64'd1);
        send_range(5, bits_q.size(), 0);
        chk("busy_after_eof", 64'(busy), 64'd0);
        send_rec(3);

        // frame A with CRC LSB flipped
        push_exp(K_CRC, 11'h0, 1'b0, 4'd0, 64'h0, 1'b0);
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 1'b1, 15'h0001);
        send_range(0, hdr_len + 16, 0);
        chk("crc_err_timing", 64'(crc_err), 64'd1);
        @(negedge CLK);
        chk("crc_err_width", 64'(crc_err), 64'd0);
        chk("hold_id", 64'(id), 64'h123);
        chk("hold_data", data, 64'hABCD_0000_0000_0000);
        chk("hold_dlc", 64'(dlc), 64'd2);
        send_rec(11);

        // RTR frame: no data field
        push_exp(K_FRAME, 11'h5A5, 1'b1, 4'd4, 64'h0, 1'b0);
        build(11'h5A5, 1'b1, 1'b0, 4'd4, 64'hFFFF_FFFF_0000_0000, 1'b0, 15'h0);
        send_range(0, bits_q.size(), 0);
        send_rec(3);

        // DLC=15 clamps to 8 bytes
        push_exp(K_FRAME, 11'h0F0, 1'b0, 4'd15, 64'h0102030405060708, 1'b1);
        build(11'h0F0, 1'b0, 1'b0, 4'd15, 64'h0102030405060708, 1'b1, 15'h0);
        send_range(0, bits_q.size(), 0);
        send_rec(3);

        // extended frame
        push_exp(K_EXT, 11'h0, 1'b0, 4'd0, 64'h0, 1'b0);
        build(11'h321, 1'b0, 1'b1, 4'd1, 64'h0, 1'b1, 15'h0);
        send_range(0, 14, 0);
        chk("ext_busy", 64'(busy), 64'd0);
        send_rec(5);
        send_bit(1'b0);
        send_bit(1'b0);
        chk("ext_no_sof", 64'(busy), 64'd0);
        send_rec(11);

        // dominant at EOF bit 4
        push_exp(K_FORM, 11'h0, 1'b0, 4'd0, 64'h0, 1'b0);
        build(11'h456, 1'b0, 1'b0, 4'd1, 64'h5A00_0000_0000_0000, 1'b1, 15'h0);
        bits_q[hdr_len + 18 + 3] = 1'b0;
        send_range(0, hdr_len + 18 + 4, 0);
        chk("form_hold_id", 64'(id), 64'h0F0);
        send_rec(11);

        // frame A with random inter-strobe gaps
        push_exp(K_FRAME, 11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 1'b1);
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 1'b1, 15'h0);
        send_range(0, bits_q.size(), 5);
        send_rec(3);

        // reset during DATA
        build(11'h3C3, 1'b0, 1'b0, 4'd3, 64'h1122_3300_0000_0000, 1'b1, 15'h0);
        send_range(0, hdr_len - 10, 0);
        chk("busy_in_data", 64'(busy), 64'd1);
        RST_N = 1'b0;
        @(negedge CLK);
        chk_zero("midreset");
        RST_N = 1'b1;
        @(negedge CLK);
        send_rec(5);
        send_bit(1'b0);
        send_bit(1'b0);
        chk("rst_no_sof", 64'(busy), 64'd0);
        send_rec(11);

        // back-to-back frames with exactly IFS_BITS between them
        push_exp(K_FRAME, 11'h7FF, 1'b0, 4'd8, 64'hDEAD_BEEF_0123_4567, 1'b1);
        build(11'h7FF, 1'b0, 1'b0, 4'd8, 64'hDEAD_BEEF_0123_4567, 1'b1, 15'h0);
        send_range(0, bits_q.size(), 0);
        send_rec(3);
        push_exp(K_FRAME, 11'h001, 1'b0, 4'd1, 64'h8000_0000_0000_0000, 1'b0);
        build(11'h001, 1'b0, 1'b0, 4'd1, 64'h8000_0000_0000_0000, 1'b0, 15'h0);
        send_range(0, bits_q.size(), 0);
        send_rec(3);

        repeat (5) @(negedge CLK);
        chk("pending_expected", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
